// File: rtl/fas_pkg.sv
// Shared definitions for the FFT frame bus: geometry, bin field slices,
// transmitter state encoding and a widening absolute-value helper.
package fas_pkg;

    localparam int NBIN   = 16;
    localparam int DW     = 32;
    localparam int IDXW   = 4;
    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // 17-bit result so that |-32768| = 32768 is representable
    function automatic logic [16:0] abs16(input logic [15:0] x);
        logic [16:0] xe;
        xe = {x[15], x};
        return xe[16] ? (17'd0 - xe) : xe;
    endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One ping-pong half: 16x32 register bank loaded by a capture strobe,
// full flag (capture sets, clear frees; capture wins) and index read mux.
module fft_frame_buf
    import fas_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cap,
    input  logic            i_clr,
    input  logic [DW-1:0]   i_d [NBIN],
    input  logic [IDXW-1:0] i_idx,
    output logic            o_full,
    output logic [DW-1:0]   o_data
);

    logic [DW-1:0] r_bank [NBIN];
    logic          r_full;

    always_ff @(posedge clk) begin
        if (i_cap) begin
            r_bank <= i_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
        end else if (i_cap) begin
            r_full <= 1'b1;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_bank[i_idx];

endmodule

// File: rtl/fft_frame_tx.sv
// FFT frame transmitter: captures 16-bin frames into a ping-pong buffer and
// streams them oldest-first on a valid/ready link. Option: FFT_TX_MAG_EN adds tx_mag.
module fft_frame_tx
    import fas_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [DW-1:0]   fft_d0,
    input  logic [DW-1:0]   fft_d1,
    input  logic [DW-1:0]   fft_d2,
    input  logic [DW-1:0]   fft_d3,
    input  logic [DW-1:0]   fft_d4,
    input  logic [DW-1:0]   fft_d5,
    input  logic [DW-1:0]   fft_d6,
    input  logic [DW-1:0]   fft_d7,
    input  logic [DW-1:0]   fft_d8,
    input  logic [DW-1:0]   fft_d9,
    input  logic [DW-1:0]   fft_d10,
    input  logic [DW-1:0]   fft_d11,
    input  logic [DW-1:0]   fft_d12,
    input  logic [DW-1:0]   fft_d13,
    input  logic [DW-1:0]   fft_d14,
    input  logic [DW-1:0]   fft_d15,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [DW-1:0]   tx_data,
    output logic [IDXW-1:0] tx_idx,
    output logic            tx_sof,
    output logic            tx_eof,
    output logic            busy,
`ifdef FFT_TX_MAG_EN
    output logic [16:0]     tx_mag,
`endif
    output logic            drop
);

    tx_state_t       r_state, w_state_nxt;
    logic [IDXW-1:0] r_idx;
    logic            r_rd, r_wr, r_drop;
    logic [DW-1:0]   w_frame [NBIN];
    logic [DW-1:0]   w_rdata [2];
    logic [1:0]      w_full, w_cap, w_clr, w_full_nxt;
    logic            w_xfer, w_last, w_wr_free, w_accept;

    always_comb begin
        w_frame[0]  = fft_d0;   w_frame[1]  = fft_d1;
        w_frame[2]  = fft_d2;   w_frame[3]  = fft_d3;
        w_frame[4]  = fft_d4;   w_frame[5]  = fft_d5;
        w_frame[6]  = fft_d6;   w_frame[7]  = fft_d7;
        w_frame[8]  = fft_d8;   w_frame[9]  = fft_d9;
        w_frame[10] = fft_d10;  w_frame[11] = fft_d11;
        w_frame[12] = fft_d12;  w_frame[13] = fft_d13;
        w_frame[14] = fft_d14;  w_frame[15] = fft_d15;
    end

    // Writes and reads both alternate buffers, so r_wr == r_rd whenever both are full
    assign w_xfer     = tx_valid && tx_ready;
    assign w_last     = w_xfer && (r_idx == IDXW'(NBIN - 1));
    assign w_wr_free  = !w_full[r_wr] || (w_last && (r_rd == r_wr));
    assign w_accept   = fft_valid && w_wr_free;
    assign w_cap      = w_accept ? (r_wr ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr      = w_last   ? (r_rd ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_nxt = w_cap | (w_full & ~w_clr);

    for (genvar g = 0; g < 2; g++) begin : g_buf
        fft_frame_buf u_buf (
            .clk    (clk),
            .rst    (rst),
            .i_cap  (w_cap[g]),
            .i_clr  (w_clr[g]),
            .i_d    (w_frame),
            .i_idx  (r_idx),
            .o_full (w_full[g]),
            .o_data (w_rdata[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= fft_valid && !w_wr_free;
            if (w_accept) begin
                r_wr <= ~r_wr;
            end
            if (w_last) begin
                r_idx <= '0;
                r_rd  <= ~r_rd;
            end else if (w_xfer) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_full_nxt) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (w_last && !(|w_full_nxt)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign tx_data = tx_valid ? w_rdata[r_rd] : '0;
    assign tx_idx  = r_idx;
    assign tx_sof  = tx_valid && (r_idx == '0);
    assign tx_eof  = tx_valid && (r_idx == IDXW'(NBIN - 1));
    assign busy    = (|w_full) || (r_state == SEND);
    assign drop    = r_drop;

`ifdef FFT_TX_MAG_EN
    assign tx_mag = abs16(tx_data[RE_MSB:RE_LSB]) + abs16(tx_data[IM_MSB:IM_LSB]);
`endif

endmodule

// File: tb/tb_fft_frame_tx.sv
// Bench for fft_frame_tx: frame-queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_fft_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fft_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] d [16];
    logic        tx_valid, tx_sof, tx_eof, busy, drop;
    logic [31:0] tx_data;
    logic [3:0]  tx_idx;
`ifdef FFT_TX_MAG_EN
    logic [16:0] tx_mag;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_vcyc = 0;
    int n_beats = 0;

    always #5 clk = ~clk;

    fft_frame_tx dut (
        .clk(clk), .rst(rst_n), .fft_valid(fft_valid),
        .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
        .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
        .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_idx(tx_idx), .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy),
`ifdef FFT_TX_MAG_EN
        .tx_mag(tx_mag),
`endif
        .drop(drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: up to two frames held, flattened 16 words each; pos = next bin of oldest
    logic [31:0] mq[$];
    int          pos = 0;
    logic        mdrop = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            pos   = 0;
            mdrop = 1'b0;
        end else begin
            if (mq.size() > 0 && tx_ready) begin
                if (pos == 15) begin
                    for (int k = 0; k < 16; k++) void'(mq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            mdrop = 1'b0;
            if (fft_valid) begin
                if (mq.size() < 32) begin
                    for (int k = 0; k < 16; k++) mq.push_back(d[k]);
                end else begin
                    mdrop = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ed;
        ev = (mq.size() > 0);
        ed = ev ? mq[pos] : 32'd0;
        check("m_valid", 32'(tx_valid), 32'(ev));
        check("m_data",  tx_data, ed);
        check("m_idx",   32'(tx_idx), ev ? 32'(pos) : 32'd0);
        check("m_sof",   32'(tx_sof), 32'(ev && pos == 0));
        check("m_eof",   32'(tx_eof), 32'(ev && pos == 15));
        check("m_busy",  32'(busy), 32'(ev));
        check("m_drop",  32'(drop), 32'(mdrop));
`ifdef FFT_TX_MAG_EN
        begin
            int re, im;
            re = int'($signed(ed[31:16]));
            im = int'($signed(ed[15:0]));
            if (re < 0) re = -re;
            if (im < 0) im = -im;
            check("m_mag", 32'(tx_mag), 32'(re + im));
        end
`endif
        if (tx_valid) n_vcyc++;
        if (tx_valid && tx_ready) n_beats++;
    end

    task automatic load(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 16; k++) d[k] = base + step * 32'(k);
    endtask

    task automatic pulse();
        fft_valid = 1'b1;
        @(posedge clk); #1;
        fft_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        load(32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_drop",  32'(drop), 32'd0);

        // Single frame, ready held high
        tx_ready = 1'b1;
        @(posedge clk); #1;
        load(32'h0, 32'h0100_0000);
        pulse();
        @(negedge clk);
        check("t1_sof",  32'(tx_sof), 32'd1);
        check("t1_data0", tx_data, 32'h0000_0000);
        repeat (15) @(negedge clk);
        check("t1_eof",  32'(tx_eof), 32'd1);
        check("t1_idx15", 32'(tx_idx), 32'd15);
        check("t1_data15", tx_data, 32'h0F00_0000);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd0);

        // Backpressure: ready toggles, first valid cycle has ready high
        @(posedge clk); #1;
        tx_ready = 1'b0;
        load(32'h2000_0000, 32'h11);
        n_vcyc = 0;
        n_beats = 0;
        pulse();
        tx_ready = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            tx_ready = ~tx_ready;
        end
        tx_ready = 1'b0;
        check("t2_vcycles", 32'(n_vcyc), 32'd31);
        check("t2_beats",   32'(n_beats), 32'd16);

        // Overflow: A, B, C back to back with ready low
        load(32'hA000_0000, 32'h1); fft_valid = 1'b1;
        @(posedge clk); #1;
        load(32'hB000_0000, 32'h1);
        @(posedge clk); #1;
        load(32'hC000_0000, 32'h1);
        @(posedge clk); #1;
        fft_valid = 1'b0;
        @(negedge clk);
        check("t3_drop", 32'(drop), 32'd1);
        @(negedge clk);
        check("t3_drop_off", 32'(drop), 32'd0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("t3_valid", 32'(tx_valid), 32'd1);
            check("t3_data", tx_data, (i < 16) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i - 16));
        end
        @(negedge clk);
        check("t3_idle", 32'(busy), 32'd0);

        // Boundary: new frame coincides with idx-15 transfer of A while B is held
        @(posedge clk); #1;
        tx_ready = 1'b0;
        load(32'h4A00_0000, 32'h1); fft_valid = 1'b1;
        @(posedge clk); #1;
        load(32'h4B00_0000, 32'h1);
        @(posedge clk); #1;
        fft_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        load(32'h4E00_0000, 32'h1);
        pulse();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("t4_drop", 32'(drop), 32'd0);
            check("t4_data", tx_data, (i < 16) ? 32'h4B00_0000 + 32'(i) : 32'h4E00_0000 + 32'(i - 16));
        end
        @(negedge clk);

        // Async reset mid-frame at idx 7
        @(posedge clk); #1;
        load(32'h5000_0000, 32'h1);
        pulse();
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_idx7_valid", 32'(tx_valid), 32'd0);
        check("t5_data", tx_data, 32'd0);
        check("t5_idx",  32'(tx_idx), 32'd0);
        check("t5_sof",  32'(tx_sof), 32'd0);
        check("t5_eof",  32'(tx_eof), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drop", 32'(drop), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        load(32'h6000_0000, 32'h1);
        pulse();
        @(negedge clk);
        check("t5_new_sof",  32'(tx_sof), 32'd1);
        check("t5_new_idx",  32'(tx_idx), 32'd0);
        check("t5_new_data", tx_data, 32'h6000_0000);
        repeat (18) @(negedge clk);

`ifdef FFT_TX_MAG_EN
        @(posedge clk); #1;
        load(32'h0, 32'h0);
        d[0] = 32'h8000_7FFF;
        d[1] = 32'h8000_8000;
        pulse();
        @(negedge clk);
        check("t6_mag_7fff", 32'(tx_mag), 32'd65535);
        @(negedge clk);
        check("t6_mag_8000", 32'(tx_mag), 32'd65536);
        repeat (16) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
